gf_div_seq: RTL

//   Sequential GF(2^M) divider: computes q = a / b = a * b^(2^M-2) by iterated square-and-multiply

---
 rtl/gf_div_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gf_div_seq.sv
// Sequential GF(2^M) divider: q = a * b^(2^M-2) by iterated square-and-multiply,
// one division in flight, valid/ready handshake on both sides.
module gf_div_seq #(
  parameter int unsigned M_P    = 8,
  parameter logic [M_P:0] POLY_P = 9'h11B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ing_valid,
  output logic           ing_ready,
  input  logic [M_P-1:0] ing_dividend,
  input  logic [M_P-1:0] ing_divisor,
  output logic           egr_valid,
  input  logic           egr_ready,
  output logic [M_P-1:0] egr_quotient,
  output logic           egr_div_by_zero
);

  localparam int unsigned CNT_W = (M_P > 2) ? $clog2(M_P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M_P - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_OUTPUT
  } state_t;

  state_t           state_q, state_d;
  logic [M_P-1:0]   acc_q, acc_d;
  logic [M_P-1:0]   sq_q, sq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ing_ready_q, ing_ready_d;
  logic             egr_valid_q, egr_valid_d;
  logic [M_P-1:0]   quo_q, quo_d;
  logic             dbz_q, dbz_d;
  logic [M_P-1:0]   prod;

  // Shift-and-add multiply; the running multiplicand is reduced as it is doubled.
  function automatic logic [M_P-1:0] gf_mul(input logic [M_P-1:0] x, input logic [M_P-1:0] y);
    logic [M_P-1:0] p;
    logic [M_P-1:0] t;
    p = '0;
    t = x;
    for (int unsigned i = 0; i < M_P; i++) begin
      if (y[i]) p = p ^ t;
      t = t[M_P-1] ? ((t << 1) ^ POLY_P[M_P-1:0]) : (t << 1);
    end
    return p;
  endfunction

  assign prod = gf_mul(acc_q, sq_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sq_d        = sq_q;
    cnt_d       = cnt_q;
    ing_ready_d = ing_ready_q;
    egr_valid_d = egr_valid_q;
    quo_d       = quo_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (ing_valid && ing_ready_q) begin
          ing_ready_d = 1'b0;
          if (ing_divisor == '0) begin
            state_d     = ST_OUTPUT;
            quo_d       = '0;
            dbz_d       = 1'b1;
            egr_valid_d = 1'b1;
          end else begin
            state_d = ST_COMPUTE;
            acc_d   = ing_dividend;
            sq_d    = gf_mul(ing_divisor, ing_divisor);
            cnt_d   = '0;
          end
        end
      end
      ST_COMPUTE: begin
        acc_d = prod;
        sq_d  = gf_mul(sq_q, sq_q);
        cnt_d = cnt_q + CNT_W'(1);
        // Multiply number M_P-1 completes the inverse exponent 2+4+..+2^(M_P-1).
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_OUTPUT;
          quo_d       = prod;
          dbz_d       = 1'b0;
          egr_valid_d = 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (egr_ready) begin
          state_d     = ST_IDLE;
          egr_valid_d = 1'b0;
          ing_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        ing_ready_d = 1'b1;
        egr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      sq_q        <= '0;
      cnt_q       <= '0;
      ing_ready_q <= 1'b1;
      egr_valid_q <= 1'b0;
      quo_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sq_q        <= sq_d;
      cnt_q       <= cnt_d;
      ing_ready_q <= ing_ready_d;
      egr_valid_q <= egr_valid_d;
      quo_q       <= quo_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ing_ready       = ing_ready_q;
  assign egr_valid       = egr_valid_q;
  assign egr_quotient    = quo_q;
  assign egr_div_by_zero = dbz_q;

endmodule
